// File: rtl/hanning_window_stage.sv
// Hann window stage: pulls one NSamples frame over ready/valid, scales each sample by a
// Hann coefficient and emits it as an sop/eop packet through a 2-stage stallable pipeline.
module hanning_window_stage #(
    parameter int W         = 16,
    parameter int NSamples  = 1024,
    parameter int CW        = 16,
    parameter     COEF_FILE = "hann_1024.hex"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_sop,
    output logic         out_eop,
    input  logic         out_ready,
    output logic         frame_done
);
    localparam int IW = $clog2(NSamples);
    localparam int PW = W + CW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Same table as the COEF_FILE image, evaluated at elaboration so the ROM needs no load step.
    function automatic logic [CW-1:0] hann_coef(input int n);
        real pi;
        real x;
        pi = 3.14159265358979323846;
        x  = (2.0 ** CW - 1.0) * 0.5 * (1.0 - $cos(2.0 * pi * n / (NSamples - 1)));
        return CW'($rtoi(x + 0.5));
    endfunction

    logic [CW-1:0] coef_rom [NSamples];

    for (genvar n = 0; n < NSamples; n++) begin : g_rom
        localparam logic [CW-1:0] COEF = hann_coef(n);
        assign coef_rom[n] = COEF;
    end

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        idx;
    logic                 en;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 last_in;

    logic                 s1_valid;
    logic                 s1_sop;
    logic                 s1_eop;
    logic signed [W-1:0]  s1_data;
    logic [CW-1:0]        s1_coef;
    logic signed [PW-1:0] prod;

    assign en         = !out_valid || out_ready;
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign last_in    = (idx == IW'(NSamples - 1));
    assign frame_done = out_xfer && out_eop;

    // NOTE: reset is folded into in_ready combinationally so the upstream buffer sees
    // back-pressure the moment reset asserts, not one edge later.
    assign in_ready = !reset && en && (state != DRAIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: combinational blocks use blocking assignments and assign every output a default
    // first, so no path through the case statement leaves a latch behind.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_xfer) state_next = RUN;
            RUN:     if (in_xfer && last_in) state_next = DRAIN;
            DRAIN:   if (out_xfer && out_eop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, which is what makes the two stages behave as a pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (in_xfer) begin
            idx <= idx + 1'b1;
        end
    end

    // NOTE: datapath registers are reset along with the valids so out_data reads 0 during
    // reset; the coefficient ROM itself is constant and never needs a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_data  <= '0;
            s1_coef  <= '0;
        end else if (en) begin
            s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_data <= $signed(in_data);
                s1_coef <= coef_rom[idx];
                s1_sop  <= (idx == '0);
                s1_eop  <= last_in;
            end
        end
    end

    assign prod = PW'(s1_data) * PW'($signed({1'b0, s1_coef}));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_sop   <= s1_valid && s1_sop;
            out_eop   <= s1_valid && s1_eop;
            out_data  <= W'(prod >>> CW);
        end
    end

endmodule

// File: tb/tb_hanning_window_stage.sv
// Self-checking bench for hanning_window_stage: directed frames, a stimulus table and
// randomized traffic, all checked against a frame-level scoreboard model.
module tb_hanning_window_stage;
    localparam int W  = 16;
    localparam int N  = 1024;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_sop;
    logic         out_eop;
    logic         out_ready;
    logic         frame_done;

    hanning_window_stage #(.W(W), .NSamples(N), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit sop;
        bit eop;
    } beat_t;

    typedef struct {
        int frame;
        int k;
        int exp_val;
    } vec_t;

    beat_t        exp_q[$];
    int           w_tab[N];
    int           cap[N];
    int           ref_cap[2][N];
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           model_idx = 0;
    int           beat_cnt = 0;
    int           t_sop_in = 0;
    bit           draining = 1'b0;
    bit           hold_pending = 1'b0;
    bit           check_lat = 1'b0;
    logic [W-1:0] hold_data;
    logic         hold_sop;
    logic         hold_eop;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // floor(d * w / 2^CW) with plain integer arithmetic
    function automatic int model_out(input int d, input int w);
        longint p;
        longint sc;
        p  = longint'(d) * longint'(w);
        sc = longint'(1) << CW;
        if (p >= 0) return int'(p / sc);
        return int'(-((-p + sc - 1) / sc));
    endfunction

    function automatic int next_data(input int mode);
        logic [15:0] r;
        r = 16'($urandom);
        case (mode)
            0:       return 16384;
            1:       return -16384;
            default: return int'($signed(r));
        endcase
    endfunction

    function automatic bit ready_value(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return $urandom_range(99) < 70;
        endcase
    endfunction

    // Called with inputs settled, away from the rising edge; returns whether an input was taken.
    task automatic observe(output bit acc_now);
        bit    exp_ready;
        beat_t e;
        exp_ready = !(out_valid && !out_ready) && !draining;
        check("in_ready", in_ready, exp_ready);

        if (hold_pending) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
            check("hold_sop", out_sop, hold_sop);
            check("hold_eop", out_eop, hold_eop);
        end
        hold_pending = out_valid && !out_ready;
        hold_data    = out_data;
        hold_sop     = out_sop;
        hold_eop     = out_eop;

        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", int'($signed(out_data)), e.data);
                check("out_sop", out_sop, e.sop);
                check("out_eop", out_eop, e.eop);
                check("frame_done", frame_done, e.eop);
                if (beat_cnt < N) cap[beat_cnt] = int'($signed(out_data));
                if (check_lat && e.sop) check("sop_latency", cyc - t_sop_in, 2);
                if (e.eop) begin
                    check("beats_per_frame", beat_cnt + 1, N);
                    beat_cnt = 0;
                    draining = 1'b0;
                end else begin
                    beat_cnt++;
                end
            end
        end else begin
            check("frame_done_idle", frame_done, 0);
        end

        acc_now = in_valid && in_ready;
        if (acc_now) begin
            exp_q.push_back('{model_out(int'($signed(in_data)), w_tab[model_idx]),
                              model_idx == 0, model_idx == N - 1});
            if (model_idx == 0) t_sop_in = cyc;
            if (model_idx == N - 1) draining = 1'b1;
            model_idx = (model_idx + 1) % N;
        end
        cyc++;
    endtask

    task automatic cycle(output bit acc_now);
        #1;
        observe(acc_now);
        @(negedge clk);
    endtask

    task automatic feed(input int n_acc, input int data_mode, input int idle_pct,
                        input int ready_mode);
        int got;
        int budget;
        int d;
        bit acc;
        got    = 0;
        budget = 0;
        d      = next_data(data_mode);
        while (got < n_acc && budget < 20000) begin
            in_valid  = ($urandom_range(99) >= idle_pct);
            in_data   = W'(d);
            out_ready = ready_value(ready_mode);
            cycle(acc);
            if (acc) begin
                got++;
                d = next_data(data_mode);
            end
            budget++;
        end
        in_valid = 1'b0;
        check("feed_budget", budget < 20000, 1);
    endtask

    task automatic drain(input int ready_mode);
        int b;
        bit acc;
        b        = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && b < 400) begin
            out_ready = ready_value(ready_mode);
            cycle(acc);
            b++;
        end
        check("drain_budget", b < 400, 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        real  x;

        for (int i = 0; i < N; i++) begin
            x = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * i / (N - 1)));
            w_tab[i] = $rtoi(x + 0.5);
        end
        vecs[0] = '{0, 0, 0};
        vecs[1] = '{0, 511, 16383};
        vecs[2] = '{0, N - 1, 0};
        vecs[3] = '{1, 0, 0};
        vecs[4] = '{1, 511, -16384};
        vecs[5] = '{1, N - 1, 0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sop_eop", {out_sop, out_eop}, 0);
        check("rst_frame_done", frame_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // constant +16384, sink always ready
        check_lat = 1'b1;
        feed(N, 0, 0, 0);
        drain(0);
        for (int k = 0; k < N; k++) ref_cap[0][k] = cap[k];

        // constant -16384, output must be symmetric
        feed(N, 1, 0, 0);
        drain(0);
        for (int k = 0; k < N; k++) ref_cap[1][k] = cap[k];
        for (int k = 0; k < N / 2; k++) check("symmetry", ref_cap[1][k], ref_cap[1][N - 1 - k]);

        foreach (vecs[i]) begin
            check($sformatf("table_f%0d_k%0d", vecs[i].frame, vecs[i].k),
                  ref_cap[vecs[i].frame][vecs[i].k], vecs[i].exp_val);
        end

        // sink ready pattern 1,0,0,1 with random data
        check_lat = 1'b0;
        feed(N, 2, 0, 1);
        drain(1);

        // in_valid held across the frame end, then one sample of the next frame
        check_lat = 1'b1;
        feed(N + 1, 0, 0, 0);
        drain(0);
        check("t4_next_beats", beat_cnt, 1);
        check("t4_next_out", cap[0], 0);

        // asynchronous reset mid-frame
        feed(300, 2, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_sop_eop", {out_sop, out_eop}, 0);
        check("midrst_frame_done", frame_done, 0);
        exp_q.delete();
        model_idx    = 0;
        beat_cnt     = 0;
        draining     = 1'b0;
        hold_pending = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        feed(N, 2, 0, 0);
        drain(0);

        // random input gaps, output must match the first frame exactly
        feed(N, 0, 30, 0);
        drain(0);
        for (int k = 0; k < N; k++) check("gap_vs_ref", cap[k], ref_cap[0][k]);

        // fully random traffic on both sides
        check_lat = 1'b0;
        feed(N, 2, 30, 2);
        drain(2);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
